// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared widths, FSM state and owner encodings for the memory arbiter
package mem_arbiter_pkg;
  localparam int ADDR = 16;
  localparam int WORD = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request-response channels plus the memory port
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;
  logic            if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
  logic [ADDR-1:0] if_req_addr;
  logic [WORD-1:0] if_rsp_data;
  logic            d_req_valid, d_req_ready, d_req_write, d_rsp_valid, d_rsp_ready;
  logic [ADDR-1:0] d_req_addr;
  logic [WORD-1:0] d_req_wdata, d_rsp_data;
  logic [ADDR-1:0] mem_A;
  logic            mem_W;
  logic [WORD-1:0] mem_D, mem_Q;
  modport slave (
    input  if_req_valid, if_req_addr, if_rsp_ready,
           d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_rsp_ready, mem_Q,
    output if_req_ready, if_rsp_valid, if_rsp_data,
           d_req_ready, d_rsp_valid, d_rsp_data, mem_A, mem_W, mem_D
  );
  modport master (
    output if_req_valid, if_req_addr, if_rsp_ready,
           d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_rsp_ready, mem_Q,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
           d_req_ready, d_rsp_valid, d_rsp_data, mem_A, mem_W, mem_D
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-first priority select with a streak counter that forces a fetch grant
module mem_arb_pick #(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic if_valid,
  input  logic d_valid,
  output logic grant_if,
  output logic grant_d
);
  logic [3:0] streak;
  logic       guard;
  assign guard    = if_valid && streak == 4'(MAX_STREAK);
  assign grant_d  = !reset && idle && d_valid && !guard;
  assign grant_if = !reset && idle && if_valid && (!d_valid || guard);
  // a data grant with fetch waiting implies streak < MAX, so no explicit saturation is needed
  always_ff @(posedge clk)
    if (reset || grant_if || !if_valid) streak <= '0;
    else if (grant_d) streak <= streak + 4'd1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a 1-cycle registered-read memory between instruction fetch and data load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input logic            clk,
  input logic            reset,
  mem_arbiter_if.slave   bus
);
  state_t state;
  owner_t owner;
  logic   grant_if, grant_d;
  mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .clk      (clk),
    .reset    (reset),
    .idle     (state == ST_IDLE),
    .if_valid (bus.if_req_valid),
    .d_valid  (bus.d_req_valid),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );
  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;
  assign bus.mem_A = grant_d ? bus.d_req_addr : grant_if ? bus.if_req_addr : '0;
  assign bus.mem_D = grant_d ? bus.d_req_wdata : '0;
  assign bus.mem_W = grant_d && bus.d_req_write;
  always_ff @(posedge clk)
    if (reset) begin
      state            <= ST_IDLE;
      owner            <= OWN_IF;
      bus.if_rsp_valid <= 1'b0;
      bus.d_rsp_valid  <= 1'b0;
      bus.if_rsp_data  <= '0;
      bus.d_rsp_data   <= '0;
    end else
      case (state)
        ST_IDLE:
          if (grant_if || (grant_d && !bus.d_req_write)) begin
            owner <= grant_d ? OWN_D : OWN_IF;
            state <= ST_READ;
          end
        ST_READ: begin
          if (owner == OWN_D) begin
            bus.d_rsp_data  <= bus.mem_Q;
            bus.d_rsp_valid <= 1'b1;
          end else begin
            bus.if_rsp_data  <= bus.mem_Q;
            bus.if_rsp_valid <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP:
          if (owner == OWN_D ? bus.d_rsp_ready : bus.if_rsp_ready) begin
            bus.d_rsp_valid  <= 1'b0;
            bus.if_rsp_valid <= 1'b0;
            state            <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, read timing, starvation guard and reset
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [WORD-1:0] mem [0:65535];
  mem_arbiter_if bus();
  mem_arbiter #(.MAX_STREAK(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_W) mem[bus.mem_A] <= bus.mem_D;
    bus.mem_Q <= mem[bus.mem_A];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    mem[16'h0010] = 32'hDEADBEEF;
    reset = 1'b1;
    bus.if_req_valid = 1'b1; bus.if_req_addr = 16'h0010; bus.if_rsp_ready = 1'b0;
    bus.d_req_valid = 1'b1; bus.d_req_write = 1'b1; bus.d_req_addr = 16'h0040;
    bus.d_req_wdata = 32'h0; bus.d_rsp_ready = 1'b1;
    // 1: reset with both requests valid
    #1;
    chk("rst0_if_ready", 32'(bus.if_req_ready), 0);
    chk("rst0_d_ready", 32'(bus.d_req_ready), 0);
    chk("rst0_mem_W", 32'(bus.mem_W), 0);
    @(negedge clk); #1;
    chk("rst1_if_ready", 32'(bus.if_req_ready), 0);
    chk("rst1_d_ready", 32'(bus.d_req_ready), 0);
    chk("rst1_mem_W", 32'(bus.mem_W), 0);
    chk("rst1_if_rsp_valid", 32'(bus.if_rsp_valid), 0);
    chk("rst1_d_rsp_valid", 32'(bus.d_rsp_valid), 0);
    @(negedge clk);
    reset = 1'b0; bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    // 2: fetch read with consumer stalled
    @(negedge clk);
    bus.if_req_valid = 1'b1; bus.if_req_addr = 16'h0010; #1;
    chk("f_t0_ready", 32'(bus.if_req_ready), 1);
    chk("f_t0_mem_A", 32'(bus.mem_A), 32'h10);
    chk("f_t0_mem_W", 32'(bus.mem_W), 0);
    @(negedge clk);
    bus.if_req_valid = 1'b0; #1;
    chk("f_t1_rsp_valid", 32'(bus.if_rsp_valid), 0);
    @(negedge clk); #1;
    chk("f_t2_rsp_valid", 32'(bus.if_rsp_valid), 1);
    chk("f_t2_rsp_data", bus.if_rsp_data, 32'hDEADBEEF);
    @(negedge clk); #1;
    chk("f_t3_hold_valid", 32'(bus.if_rsp_valid), 1);
    chk("f_t3_hold_data", bus.if_rsp_data, 32'hDEADBEEF);
    bus.if_rsp_ready = 1'b1;
    @(negedge clk); #1;
    chk("f_t4_rsp_drop", 32'(bus.if_rsp_valid), 0);
    chk("f_t4_idle", 32'(dut.state), 32'(ST_IDLE));
    // 3: store then load the same address
    @(negedge clk);
    bus.d_req_valid = 1'b1; bus.d_req_write = 1'b1; bus.d_req_addr = 16'h0020;
    bus.d_req_wdata = 32'h12345678; #1;
    chk("st_ready", 32'(bus.d_req_ready), 1);
    chk("st_mem_W", 32'(bus.mem_W), 1);
    chk("st_mem_A", 32'(bus.mem_A), 32'h20);
    chk("st_mem_D", bus.mem_D, 32'h12345678);
    @(negedge clk);
    bus.d_req_write = 1'b0; #1;
    chk("ld_ready", 32'(bus.d_req_ready), 1);
    chk("ld_mem_W", 32'(bus.mem_W), 0);
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    @(negedge clk); #1;
    chk("ld_rsp_valid", 32'(bus.d_rsp_valid), 1);
    chk("ld_rsp_data", bus.d_rsp_data, 32'h12345678);
    // 4: simultaneous fetch and load, data first
    @(negedge clk);
    bus.if_req_valid = 1'b1; bus.if_req_addr = 16'h0010;
    bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 16'h0020; #1;
    chk("both_d_ready", 32'(bus.d_req_ready), 1);
    chk("both_if_ready", 32'(bus.if_req_ready), 0);
    @(negedge clk);
    bus.d_req_valid = 1'b0; #1;
    chk("both_read_if_wait", 32'(bus.if_req_ready), 0);
    @(negedge clk); #1;
    chk("both_resp_if_wait", 32'(bus.if_req_ready), 0);
    chk("both_d_rsp", bus.d_rsp_data, 32'h12345678);
    @(negedge clk); #1;
    chk("both_if_granted", 32'(bus.if_req_ready), 1);
    @(negedge clk);
    bus.if_req_valid = 1'b0;
    @(negedge clk); #1;
    chk("both_if_rsp_data", bus.if_rsp_data, 32'hDEADBEEF);
    chk("both_if_rsp_valid", 32'(bus.if_rsp_valid), 1);
    // 5: back-to-back stores with fetch waiting
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.if_req_valid = 1'b1; bus.if_req_addr = 16'h0010;
      bus.d_req_valid = 1'b1; bus.d_req_write = 1'b1;
      bus.d_req_addr = 16'h0030 + 16'(i); bus.d_req_wdata = 32'hA0000000 + 32'(i); #1;
      chk($sformatf("streak_st%0d_d_ready", i), 32'(bus.d_req_ready), 1);
      chk($sformatf("streak_st%0d_if_ready", i), 32'(bus.if_req_ready), 0);
      chk($sformatf("streak_st%0d_mem_W", i), 32'(bus.mem_W), 1);
    end
    @(negedge clk); #1;
    chk("streak_at_max", 32'(dut.u_pick.streak), 4);
    chk("streak_guard_d_ready", 32'(bus.d_req_ready), 0);
    chk("streak_guard_if_ready", 32'(bus.if_req_ready), 1);
    chk("streak_guard_mem_W", 32'(bus.mem_W), 0);
    @(negedge clk);
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0; #1;
    chk("streak_cleared", 32'(dut.u_pick.streak), 0);
    @(negedge clk); #1;
    chk("streak_if_rsp", bus.if_rsp_data, 32'hDEADBEEF);
    // 6: reset while a load response is pending
    @(negedge clk);
    bus.d_rsp_ready = 1'b0;
    bus.d_req_valid = 1'b1; bus.d_req_write = 1'b0; bus.d_req_addr = 16'h0032;
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    @(negedge clk); #1;
    chk("rr_d_rsp_valid", 32'(bus.d_rsp_valid), 1);
    chk("rr_d_rsp_data", bus.d_rsp_data, 32'hA0000002);
    reset = 1'b1; bus.d_req_valid = 1'b1; bus.d_req_write = 1'b1; #1;
    chk("rr_mem_W", 32'(bus.mem_W), 0);
    chk("rr_d_ready", 32'(bus.d_req_ready), 0);
    @(negedge clk); #1;
    chk("rr_d_rsp_cleared", 32'(bus.d_rsp_valid), 0);
    chk("rr_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("rr_mem_W_after", 32'(bus.mem_W), 0);
    reset = 1'b0; bus.d_req_valid = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
